// File: rtl/regfile_check_ctrl.sv
// regfile_check_ctrl
//   Hardware self-check controller that sits downstream of a processor and its
//   register file. The controller first lets the CPU run for NUM_CYCLES clocks
//   and counts real register writebacks. It then takes over regfile read port
//   A, walks registers 0..NUM_REGS-1 and compares each one against a
//   synchronous expected-value ROM. It reports the failures and a final pass
//   flag.
//
// Ports
//   clock            system clock, all state on rising edge
//   reset            asynchronous, active-low
//   ctrl_writeEnable snooped regfile write enable
//   ctrl_writeReg    snooped regfile write index
//   data_readRegA    regfile port A data (combinational from test_reg)
//   test_mode        1 = controller owns port A select
//   test_reg         register index driven onto port A
//   exp_addr         expected-value ROM address
//   exp_data         ROM data, valid one clock after exp_addr
//   cycle_count      RUN cycles elapsed
//   write_count      saturating count of writes to non-zero registers during RUN
//   mismatch         one-clock pulse per failing register
//   mismatch_reg     index of the register flagged by mismatch
//   error_count      total failing registers
//   first_fail_reg   index of first failure (valid with first_fail_valid)
//   first_fail_valid sticky first-failure flag
//   done             scan finished, sticky until reset
//   pass             done and no failures
module regfile_check_ctrl #(
    parameter int NUM_CYCLES = 255,
    parameter int NUM_REGS   = 32,
    parameter int CW         = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ctrl_writeEnable,
    input  logic [4:0]    ctrl_writeReg,
    input  logic [31:0]   data_readRegA,
    output logic          test_mode,
    output logic [4:0]    test_reg,
    output logic [4:0]    exp_addr,
    input  logic [31:0]   exp_data,
    output logic [CW-1:0] cycle_count,
    output logic [15:0]   write_count,
    output logic          mismatch,
    output logic [4:0]    mismatch_reg,
    output logic [5:0]    error_count,
    output logic [4:0]    first_fail_reg,
    output logic          first_fail_valid,
    output logic          done,
    output logic          pass
);

    typedef enum logic [1:0] {S_RUN, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [CW-1:0] LAST_CYC = CW'(NUM_CYCLES - 1);
    localparam logic [4:0]    LAST_IDX = 5'(NUM_REGS - 1);

    state_t        state_q;
    logic [CW-1:0] cycle_q;
    logic [15:0]   wcnt_q;
    logic [4:0]    idx_q;
    logic          vld_q;
    logic [4:0]    cap_idx_q;
    logic [31:0]   act_q;
    logic          test_mode_q;
    logic          mismatch_q;
    logic [4:0]    mismatch_reg_q;
    logic [5:0]    err_q;
    logic [4:0]    ffr_q;
    logic          ffv_q;
    logic          done_q;
    logic          pass_q;

    logic          fail_d;
    logic [5:0]    err_d;

    // Compare stage: act_q was captured last clock, and the ROM word for the
    // same index arrives now because the ROM read has one clock of latency.
    always_comb begin
        fail_d = vld_q && (act_q != exp_data);
        err_d  = err_q + 6'(fail_d);
    end

    // Captured read data is a pure datapath register; vld_q qualifies it.
    always_ff @(posedge clock) begin
        if (state_q == S_SCAN) begin
            act_q <= data_readRegA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_RUN;
            cycle_q        <= '0;
            wcnt_q         <= '0;
            idx_q          <= '0;
            vld_q          <= 1'b0;
            cap_idx_q      <= '0;
            test_mode_q    <= 1'b0;
            mismatch_q     <= 1'b0;
            mismatch_reg_q <= '0;
            err_q          <= '0;
            ffr_q          <= '0;
            ffv_q          <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            // Result stage, runs every clock; it is idle whenever vld_q is 0.
            mismatch_q <= fail_d;
            err_q      <= err_d;
            if (fail_d) begin
                mismatch_reg_q <= cap_idx_q;
                if (!ffv_q) begin
                    ffr_q <= cap_idx_q;
                    ffv_q <= 1'b1;
                end
            end

            vld_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    cycle_q <= cycle_q + 1'b1;
                    if (ctrl_writeEnable && (ctrl_writeReg != 5'd0) && (wcnt_q != 16'hFFFF)) begin
                        wcnt_q <= wcnt_q + 16'd1;
                    end
                    if (cycle_q == LAST_CYC) begin
                        state_q     <= S_SCAN;
                        idx_q       <= '0;
                        test_mode_q <= 1'b1;
                    end
                end
                // Capture stage: sample port A for idx_q, with the ROM read in flight.
                S_SCAN: begin
                    vld_q     <= 1'b1;
                    cap_idx_q <= idx_q;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DRAIN;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                // The last compare happens on this edge, so pass uses err_d.
                S_DRAIN: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    pass_q  <= (err_d == 6'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign test_mode        = test_mode_q;
    assign test_reg         = idx_q;
    assign exp_addr         = idx_q;
    assign cycle_count      = cycle_q;
    assign write_count      = wcnt_q;
    assign mismatch         = mismatch_q;
    assign mismatch_reg     = mismatch_reg_q;
    assign error_count      = err_q;
    assign first_fail_reg   = ffr_q;
    assign first_fail_valid = ffv_q;
    assign done             = done_q;
    assign pass             = pass_q;

endmodule

// File: tb/tb_regfile_check_ctrl.sv
module tb_regfile_check_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Main instance: NUM_CYCLES=10, NUM_REGS=32
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  wr = 5'd0;
    logic [31:0] rd_a;
    logic [31:0] exp_d;
    logic        tm;
    logic [4:0]  treg, eaddr;
    logic [9:0]  cc;
    logic [15:0] wc;
    logic        mm;
    logic [4:0]  mmr;
    logic [5:0]  ec;
    logic [4:0]  ffr;
    logic        ffv, dn, ps;
    logic [31:0] regs [32];
    logic [31:0] rom  [32];

    assign rd_a = regs[treg];
    always @(posedge clk) exp_d <= rom[eaddr];

    regfile_check_ctrl #(.NUM_CYCLES(10), .NUM_REGS(32), .CW(10)) dut (
        .clock(clk), .reset(rst_n), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
        .data_readRegA(rd_a), .test_mode(tm), .test_reg(treg), .exp_addr(eaddr),
        .exp_data(exp_d), .cycle_count(cc), .write_count(wc), .mismatch(mm),
        .mismatch_reg(mmr), .error_count(ec), .first_fail_reg(ffr),
        .first_fail_valid(ffv), .done(dn), .pass(ps)
    );

    // Instance B: NUM_CYCLES=1, NUM_REGS=1, r0=0, ROM[0]=0
    logic        rst_b = 1'b0;
    logic [31:0] rd_b = 32'd0;
    logic [31:0] exp_b;
    logic        tm_b, mm_b, ffv_b, dn_b, ps_b;
    logic [4:0]  treg_b, eaddr_b, mmr_b, ffr_b;
    logic [0:0]  cc_b;
    logic [15:0] wc_b;
    logic [5:0]  ec_b;

    always @(posedge clk) exp_b <= 32'd0;

    regfile_check_ctrl #(.NUM_CYCLES(1), .NUM_REGS(1), .CW(1)) dut_b (
        .clock(clk), .reset(rst_b), .ctrl_writeEnable(1'b0), .ctrl_writeReg(5'd0),
        .data_readRegA(rd_b), .test_mode(tm_b), .test_reg(treg_b), .exp_addr(eaddr_b),
        .exp_data(exp_b), .cycle_count(cc_b), .write_count(wc_b), .mismatch(mm_b),
        .mismatch_reg(mmr_b), .error_count(ec_b), .first_fail_reg(ffr_b),
        .first_fail_valid(ffv_b), .done(dn_b), .pass(ps_b)
    );

    // Instance C: long RUN phase to reach write_count saturation
    logic        rst_c = 1'b0;
    logic [31:0] rd_c = 32'd0;
    logic [31:0] exp_c = 32'd0;
    logic        tm_c, mm_c, ffv_c, dn_c, ps_c;
    logic [4:0]  treg_c, eaddr_c, mmr_c, ffr_c;
    logic [16:0] cc_c;
    logic [15:0] wc_c;
    logic [5:0]  ec_c;

    regfile_check_ctrl #(.NUM_CYCLES(65540), .NUM_REGS(1), .CW(17)) dut_c (
        .clock(clk), .reset(rst_c), .ctrl_writeEnable(1'b1), .ctrl_writeReg(5'd1),
        .data_readRegA(rd_c), .test_mode(tm_c), .test_reg(treg_c), .exp_addr(eaddr_c),
        .exp_data(exp_c), .cycle_count(cc_c), .write_count(wc_c), .mismatch(mm_c),
        .mismatch_reg(mmr_c), .error_count(ec_c), .first_fail_reg(ffr_c),
        .first_fail_valid(ffv_c), .done(dn_c), .pass(ps_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Scoreboard of expected mismatch register indices for the main instance
    int exp_q[$];

    always @(negedge clk) begin
        if (mm === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL mismatch_unexpected: got reg %0d required no pulse", mmr);
            end else begin
                check("mismatch_reg", 32'(mmr), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drive inputs for the next rising edge, then land on the following falling edge
    task automatic step(input logic e, input logic [4:0] r);
        we = e;
        wr = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_pattern(input int k, output logic e, output logic [4:0] r);
        e = 1'b0;
        r = 5'd0;
        if (k == 1 || k == 3 || k == 6 || k == 10 || k > 10) begin e = 1'b1; r = 5'd3; end
        else if (k == 2 || k == 5) begin e = 1'b1; r = 5'd0; end
        else if (k == 4) begin e = 1'b0; r = 5'd7; end
    endtask

    logic       pe;
    logic [4:0] pr;

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = (32'(i) * 32'h01010101) ^ 32'hA5A5_5A5A;
            rom[i]  = regs[i];
        end

        // Test 1: matching ROM, write snooping
        @(negedge clk);
        check("reset_test_mode", 32'(tm), 0);
        check("reset_done", 32'(dn), 0);
        check("reset_error_count", 32'(ec), 0);
        check("reset_write_count", 32'(wc), 0);
        check("reset_cycle_count", 32'(cc), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            write_pattern(k, pe, pr);
            step(pe, pr);
            if (k == 9)  check("t1_test_mode_run", 32'(tm), 0);
            if (k == 10) check("t1_test_mode_scan", 32'(tm), 1);
            if (k == 10) check("t1_write_count_at_scan", 32'(wc), 4);
            if (k == 42) check("t1_done_early", 32'(dn), 0);
        end
        check("t1_done", 32'(dn), 1);
        check("t1_pass", 32'(ps), 1);
        check("t1_error_count", 32'(ec), 0);
        check("t1_first_fail_valid", 32'(ffv), 0);
        check("t1_write_count_frozen", 32'(wc), 4);
        check("t1_cycle_count", 32'(cc), 10);

        // Test 2: two failing registers
        regs[5] = 32'd7;  rom[5] = 32'd8;
        regs[20] = 32'd1; rom[20] = 32'd0;
        exp_q.push_back(5);
        exp_q.push_back(20);
        rst_n = 1'b0;
        step(1'b0, 5'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 43; k++) step(1'b0, 5'd0);
        check("t2_done", 32'(dn), 1);
        check("t2_error_count", 32'(ec), 2);
        check("t2_first_fail_reg", 32'(ffr), 5);
        check("t2_first_fail_valid", 32'(ffv), 1);
        check("t2_pass", 32'(ps), 0);
        check("t2_queue_drained", 32'(exp_q.size()), 0);

        // Test 3: asynchronous reset mid-SCAN
        rom[20] = regs[20];
        exp_q.push_back(5);
        rst_n = 1'b0;
        step(1'b0, 5'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) step(1'b0, 5'd0);
        check("t3_test_reg_mid", 32'(treg), 12);
        check("t3_error_count_mid", 32'(ec), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t3_async_test_mode", 32'(tm), 0);
        check("t3_async_test_reg", 32'(treg), 0);
        check("t3_async_error_count", 32'(ec), 0);
        check("t3_async_ffv", 32'(ffv), 0);
        check("t3_async_cycle_count", 32'(cc), 0);
        check("t3_async_done", 32'(dn), 0);
        @(negedge clk);
        check("t3_queue_after_first", 32'(exp_q.size()), 0);
        exp_q.push_back(5);
        rst_n = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            step(1'b0, 5'd0);
            if (k == 9)  check("t3_rerun_test_mode_run", 32'(tm), 0);
            if (k == 10) check("t3_rerun_test_mode_scan", 32'(tm), 1);
        end
        check("t3_done", 32'(dn), 1);
        check("t3_error_count", 32'(ec), 1);
        check("t3_first_fail_reg", 32'(ffr), 5);
        check("t3_pass", 32'(ps), 0);

        // Test 4: minimal configuration
        check("t4_reset_test_mode", 32'(tm_b), 0);
        rst_b = 1'b1;
        step(1'b0, 5'd0);
        check("t4_test_mode_first_clock", 32'(tm_b), 1);
        step(1'b0, 5'd0);
        check("t4_done_early", 32'(dn_b), 0);
        step(1'b0, 5'd0);
        check("t4_done", 32'(dn_b), 1);
        check("t4_pass", 32'(ps_b), 1);

        // Test 5: write_count saturation
        rst_c = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("t5_write_count_fffe", 32'(wc_c), 32'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_write_count_sat", 32'(wc_c), 32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regfile_check_ctrl.md
Name: regfile_check_ctrl

Overview:
- Hardware self-check controller downstream of the processor/regfile pair; it replaces the harness's behavioural run-then-dump sequence with synthesizable logic.
- RUN phase: lets the CPU execute for NUM_CYCLES clocks and counts real register writebacks.
- SCAN phase: takes over regfile read port A, walks every register and compares it against a synchronous expected-value ROM.
- Reports error count, first failing register and a final pass flag.

Parameters:
NUM_CYCLES, 255, clocks spent in RUN before scanning (>=1)
NUM_REGS, 32, registers scanned (1..32), indices 0..NUM_REGS-1
CW, 10, width of cycle counter; must satisfy 2^CW > NUM_CYCLES

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; reset asserted when 0
ctrl_writeEnable  in  1  regfile write enable from processor (snooped)
ctrl_writeReg  in  5  regfile write index from processor (snooped)
data_readRegA  in  32  regfile port A read data (combinational from test_reg)
test_mode  out  1  1 = controller owns regfile read port A select
test_reg  out  5  register index driven onto port A while test_mode=1
exp_addr  out  5  expected-value ROM address
exp_data  in  32  expected-value ROM data, valid one clock after exp_addr
cycle_count  out  CW  RUN cycles elapsed
write_count  out  16  writes with enable=1 and index!=0 during RUN, saturating
mismatch  out  1  one-clock pulse per failing register
mismatch_reg  out  5  index of register flagged by mismatch
error_count  out  6  total failing registers
first_fail_reg  out  5  index of first failure; valid when first_fail_valid=1
first_fail_valid  out  1  set on first failure, sticky
done  out  1  scan finished, sticky until reset
pass  out  1  done=1 and error_count=0

Behaviour:
- Reset (reset=0, async): state=RUN; all outputs 0; counters, index and pipeline valid bit cleared. Re-entry to RUN on release, including from mid-SCAN or DONE.
- States: RUN -> SCAN -> DRAIN -> DONE. DONE is terminal.
- RUN:
  - cycle_count increments each clock.
  - write_count increments when ctrl_writeEnable=1 and ctrl_writeReg!=0; it holds at 16'hFFFF.
  - On the clock where cycle_count==NUM_CYCLES-1, go to SCAN with idx=0. test_mode rises on that same edge, registered.
  - A write on the final RUN cycle is counted.
- SCAN:
  - test_reg=exp_addr=idx.
  - Each clock, capture act<=data_readRegA, set vld<=1 and cap_idx<=idx, then idx increments.
  - After issuing idx=NUM_REGS-1, go to DRAIN.
  - Snooping is disabled from SCAN onward; write_count and cycle_count freeze.
- Compare stage, one clock after capture:
  - If vld and act!=exp_data, the register fails.
  - On failure: mismatch=1, mismatch_reg=cap_idx, error_count+1.
  - If first_fail_valid=0, latch first_fail_reg=cap_idx and set first_fail_valid.
  - Compare is exact, all 32 bits. Register 0 is compared like any other.
- DRAIN: one clock for the final compare. The next edge moves to DONE and sets done; pass=(error_count==0) is evaluated including the final compare.
- test_mode stays 1 through SCAN, DRAIN and DONE, so the processor can no longer steer port A.
- Latency: done rises NUM_CYCLES + NUM_REGS + 1 clocks after reset release.
- error_count max is 32 and fits 6 bits; no saturation needed.
- mismatch is a pulse; it is 0 in every cycle with no failure.

Test Plan:
- NUM_CYCLES=10, NUM_REGS=32, ROM equal to regfile contents -> done at clock 43, pass=1, error_count=0, mismatch never asserted, first_fail_valid=0.
- r5 holds 7, ROM[5]=8, r20 holds 1, ROM[20]=0 -> two mismatch pulses with mismatch_reg 5 then 20, error_count=2, first_fail_reg=5, pass=0.
- During RUN, drive 4 writes to reg 3, 2 writes to reg 0, and one write with enable=0 -> write_count=4; writes injected during SCAN leave it at 4.
- Pull reset low mid-SCAN at idx=12 with error_count=1 -> all outputs 0 immediately (async); after release, a full RUN of NUM_CYCLES precedes a fresh scan.
- NUM_CYCLES=1, NUM_REGS=1, ROM[0]=0, r0=0 -> test_mode=1 after the first clock, done 3 clocks after release, pass=1.
- Stuck write_count: preload to 16'hFFFE and drive 3 valid writes -> write_count=16'hFFFF, no wrap.
